// File: rtl/lmc_mem_arbiter.sv
// Two-port arbiter/sequencer for the shared LMC mailbox memory (CPU + host loader).
// Optional feature: define LMC_ARB_RR_EN for round-robin on simultaneous requests (default: CPU priority).
module lmc_mem_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 11,
  parameter int MEM_DEPTH = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_lock,
  output logic              c_gnt,
  output logic              h_gnt,
  output logic              c_rvalid,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              c_err,
  output logic              h_err,
  output logic              lock_active,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state, state_nx;
  logic              lock_held;
  logic              rd_host;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
`ifdef LMC_ARB_RR_EN
  logic              favor_host;
`endif

  assign lock_active = lock_held;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    c_gnt    = 1'b0;
    h_gnt    = 1'b0;
    state_nx = state;
    if (state == IDLE) begin
      if (lock_held) begin
        h_gnt = h_req;
      end else if (c_req && h_req) begin
`ifdef LMC_ARB_RR_EN
        c_gnt = !favor_host;
        h_gnt = favor_host;
`else
        c_gnt = 1'b1;
`endif
      end else begin
        c_gnt = c_req;
        h_gnt = h_req;
      end
    end
    accept    = c_gnt || h_gnt;
    sel_we    = h_gnt ? h_we    : c_we;
    sel_addr  = h_gnt ? h_addr  : c_addr;
    sel_wdata = h_gnt ? h_wdata : c_wdata;
    in_range  = {1'b0, sel_addr} < DEPTH_L;
    case (state)
      IDLE:    if (accept && in_range && !sel_we) state_nx = RD_WAIT;
      RD_WAIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_rvalid  <= 1'b0;
      h_rvalid  <= 1'b0;
      c_rdata   <= '0;
      h_rdata   <= '0;
      c_err     <= 1'b0;
      h_err     <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      lock_held <= 1'b0;
      rd_host   <= 1'b0;
    end else begin
      // Pulses default low; only the branches below raise them for one cycle.
      mem_we   <= 1'b0;
      c_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      c_err    <= 1'b0;
      h_err    <= 1'b0;

      if (state == RD_WAIT) begin
        if (rd_host) begin
          h_rdata  <= mem_out;
          h_rvalid <= 1'b1;
        end else begin
          c_rdata  <= mem_out;
          c_rvalid <= 1'b1;
        end
      end

      if (accept) begin
        if (in_range) begin
          mem_addr <= sel_addr;
          if (sel_we) begin
            mem_data <= sel_wdata;
            mem_we   <= 1'b1;
          end else begin
            rd_host <= h_gnt;
          end
        end else begin
          // Out-of-range: memory bus untouched, error (and zero read data) returned next cycle.
          if (h_gnt) h_err <= 1'b1;
          else       c_err <= 1'b1;
          if (!sel_we) begin
            if (h_gnt) begin
              h_rvalid <= 1'b1;
              h_rdata  <= '0;
            end else begin
              c_rvalid <= 1'b1;
              c_rdata  <= '0;
            end
          end
        end
      end

      if (state == IDLE) begin
        if (h_gnt)        lock_held <= h_lock;
        else if (!h_lock) lock_held <= 1'b0;
      end
    end
  end

`ifdef LMC_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    favor_host <= 1'b0;
    else if (accept) favor_host <= c_gnt;
  end
`endif

endmodule

// File: tb/tb_lmc_mem_arbiter.sv
// Self-checking bench for lmc_mem_arbiter: directed vector table plus hand sequences
// for arbitration, lock hold/release and reset during a pending read.
module tb_lmc_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_req, c_we, h_req, h_we, h_lock;
  logic [6:0]  c_addr, h_addr;
  logic [10:0] c_wdata, h_wdata;
  logic        c_gnt, h_gnt, c_rvalid, h_rvalid, c_err, h_err, lock_active, mem_we;
  logic [10:0] c_rdata, h_rdata, mem_data, mem_out;
  logic [6:0]  mem_addr;
  logic [10:0] mem [0:127];

  int n_checks = 0;
  int n_fail   = 0;

  lmc_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
    .c_gnt(c_gnt), .h_gnt(h_gnt), .c_rvalid(c_rvalid), .h_rvalid(h_rvalid),
    .c_rdata(c_rdata), .h_rdata(h_rdata), .c_err(c_err), .h_err(h_err),
    .lock_active(lock_active), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Behavioural mailbox memory: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data;
  assign mem_out = mem[mem_addr];

  typedef struct {
    string       nm;
    logic [1:0]  c_rw;   // {req, we}
    logic [6:0]  ca;
    logic [10:0] cd;
    logic [1:0]  h_rw;
    logic [6:0]  ha;
    logic [10:0] hd;
    logic        hl;
    logic [1:0]  e_gnt;  // {c_gnt, h_gnt}
    logic [3:0]  e_flg;  // {c_rvalid, h_rvalid, c_err, h_err}
    logic        e_we;
    logic [6:0]  e_ma;
    logic [10:0] e_md;
    logic [10:0] e_crd;
    logic [10:0] e_hrd;
    logic        e_lk;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] crw, input logic [6:0] ca, input logic [10:0] cd,
                        input logic [1:0] hrw, input logic [6:0] ha, input logic [10:0] hd,
                        input logic hl);
    {c_req, c_we} = crw;
    c_addr = ca; c_wdata = cd;
    {h_req, h_we} = hrw;
    h_addr = ha; h_wdata = hd;
    h_lock = hl;
  endtask

  task automatic set_idle();
    set_in(2'b00, 7'd0, 11'd0, 2'b00, 7'd0, 11'd0, 1'b0);
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 11'd0;

    //              name          c_rw  ca      cd       h_rw  ha      hd       hl    gnt    flg      we    ma      md        crd      hrd      lk
    tbl[0]  = '{"reset",       2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b0000, 1'b0, 7'd0,   11'd0,   11'd0,   11'd0,   1'b0};
    tbl[1]  = '{"h_wr5",       2'b00, 7'd0,   11'd0,   2'b11, 7'd5,   11'd901, 1'b0, 2'b01, 4'b0000, 1'b0, 7'd0,   11'd0,   11'd0,   11'd0,   1'b0};
    tbl[2]  = '{"h_rd5",       2'b00, 7'd0,   11'd0,   2'b10, 7'd5,   11'd0,   1'b0, 2'b01, 4'b0000, 1'b1, 7'd5,   11'd901, 11'd0,   11'd0,   1'b0};
    tbl[3]  = '{"h_rdwait",    2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b0000, 1'b0, 7'd5,   11'd901, 11'd0,   11'd0,   1'b0};
    tbl[4]  = '{"h_rvalid",    2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b0100, 1'b0, 7'd5,   11'd901, 11'd0,   11'd901, 1'b0};
    tbl[5]  = '{"c_wr9",       2'b11, 7'd9,   11'd42,  2'b00, 7'd0,   11'd0,   1'b0, 2'b10, 4'b0000, 1'b0, 7'd5,   11'd901, 11'd0,   11'd901, 1'b0};
    tbl[6]  = '{"c_rd9",       2'b10, 7'd9,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b10, 4'b0000, 1'b1, 7'd9,   11'd42,  11'd0,   11'd901, 1'b0};
    tbl[7]  = '{"c_rdwait",    2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b0000, 1'b0, 7'd9,   11'd42,  11'd0,   11'd901, 1'b0};
    tbl[8]  = '{"c_rvalid",    2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b1000, 1'b0, 7'd9,   11'd42,  11'd42,  11'd901, 1'b0};
    tbl[9]  = '{"c_wr100",     2'b11, 7'd100, 11'd7,   2'b00, 7'd0,   11'd0,   1'b0, 2'b10, 4'b0000, 1'b0, 7'd9,   11'd42,  11'd42,  11'd901, 1'b0};
    tbl[10] = '{"c_rd127",     2'b10, 7'd127, 11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b10, 4'b0010, 1'b0, 7'd9,   11'd42,  11'd42,  11'd901, 1'b0};
    tbl[11] = '{"c_oor_rd",    2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b1010, 1'b0, 7'd9,   11'd42,  11'd0,   11'd901, 1'b0};
    tbl[12] = '{"h_wr99",      2'b00, 7'd0,   11'd0,   2'b11, 7'd99,  11'd555, 1'b0, 2'b01, 4'b0000, 1'b0, 7'd9,   11'd42,  11'd0,   11'd901, 1'b0};
    tbl[13] = '{"h_rd99_lk",   2'b00, 7'd0,   11'd0,   2'b10, 7'd99,  11'd0,   1'b1, 2'b01, 4'b0000, 1'b1, 7'd99,  11'd555, 11'd0,   11'd901, 1'b0};
    tbl[14] = '{"lk_rdwait",   2'b10, 7'd5,   11'd0,   2'b00, 7'd0,   11'd0,   1'b1, 2'b00, 4'b0000, 1'b0, 7'd99,  11'd555, 11'd0,   11'd901, 1'b1};
    tbl[15] = '{"lk_block1",   2'b10, 7'd5,   11'd0,   2'b00, 7'd0,   11'd0,   1'b1, 2'b00, 4'b0100, 1'b0, 7'd99,  11'd555, 11'd0,   11'd555, 1'b1};
    tbl[16] = '{"lk_block2",   2'b10, 7'd5,   11'd0,   2'b00, 7'd0,   11'd0,   1'b1, 2'b00, 4'b0000, 1'b0, 7'd99,  11'd555, 11'd0,   11'd555, 1'b1};
    tbl[17] = '{"lk_drop",     2'b10, 7'd5,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b0000, 1'b0, 7'd99,  11'd555, 11'd0,   11'd555, 1'b1};
    tbl[18] = '{"lk_freed",    2'b10, 7'd5,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b10, 4'b0000, 1'b0, 7'd99,  11'd555, 11'd0,   11'd555, 1'b0};
    tbl[19] = '{"c_rd5wait",   2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b0000, 1'b0, 7'd5,   11'd555, 11'd0,   11'd555, 1'b0};
    tbl[20] = '{"c_rd5val",    2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b1000, 1'b0, 7'd5,   11'd555, 11'd901, 11'd555, 1'b0};
    tbl[21] = '{"h_rd100",     2'b00, 7'd0,   11'd0,   2'b10, 7'd100, 11'd0,   1'b0, 2'b01, 4'b0000, 1'b0, 7'd5,   11'd555, 11'd901, 11'd555, 1'b0};
    tbl[22] = '{"h_oor_rd",    2'b00, 7'd0,   11'd0,   2'b00, 7'd0,   11'd0,   1'b0, 2'b00, 4'b0101, 1'b0, 7'd5,   11'd555, 11'd901, 11'd0,   1'b0};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      set_in(tbl[i].c_rw, tbl[i].ca, tbl[i].cd, tbl[i].h_rw, tbl[i].ha, tbl[i].hd, tbl[i].hl);
      @(negedge clk);
      check({tbl[i].nm, ".gnt"},  64'({c_gnt, h_gnt}), 64'(tbl[i].e_gnt));
      check({tbl[i].nm, ".flag"}, 64'({c_rvalid, h_rvalid, c_err, h_err}), 64'(tbl[i].e_flg));
      check({tbl[i].nm, ".mem"},  64'({mem_we, mem_addr, mem_data}),
            64'({tbl[i].e_we, tbl[i].e_ma, tbl[i].e_md}));
      check({tbl[i].nm, ".rd"},   64'({c_rdata, h_rdata}), 64'({tbl[i].e_crd, tbl[i].e_hrd}));
      check({tbl[i].nm, ".lock"}, 64'(lock_active), 64'(tbl[i].e_lk));
      next_cycle();
    end

    // Both ports read back-to-back: one grant every other cycle.
    do_reset();
    set_in(2'b10, 7'd1, 11'd0, 2'b10, 7'd2, 11'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_g;
      @(negedge clk);
      if (i % 2 == 1)      exp_g = 2'b00;
`ifdef LMC_ARB_RR_EN
      else if (i % 4 == 0) exp_g = 2'b10;
      else                 exp_g = 2'b01;
`else
      else                 exp_g = 2'b10;
`endif
      check($sformatf("arb_both.%0d", i), 64'({c_gnt, h_gnt}), 64'(exp_g));
      next_cycle();
    end

    // Host takes the lock with a read, then the CPU is starved while h_lock stays high.
    set_in(2'b00, 7'd0, 11'd0, 2'b10, 7'd3, 11'd0, 1'b1);
    @(negedge clk);
    check("lock_take.h_gnt", 64'(h_gnt), 64'(1'b1));
    next_cycle();
    set_in(2'b10, 7'd9, 11'd0, 2'b00, 7'd0, 11'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("lock_hold.c_gnt.%0d", i), 64'(c_gnt), 64'(1'b0));
      check($sformatf("lock_hold.active.%0d", i), 64'(lock_active), 64'(1'b1));
      next_cycle();
    end
    h_lock = 1'b0;
    begin
      int k;
      k = 0;
      while (k < 4) begin
        @(negedge clk);
        if (c_gnt) break;
        next_cycle();
        k++;
      end
      check("lock_release.latency", 64'(k), 64'(1));
    end
    next_cycle();
    set_idle();
    repeat (3) next_cycle();

    // Reset lands while a CPU read sits in RD_WAIT: nothing may surface afterwards.
    @(negedge clk);
    check("pre_rst.c_rdata", 64'(c_rdata), 64'(11'd42));
    next_cycle();
    set_in(2'b10, 7'd9, 11'd0, 2'b00, 7'd0, 11'd0, 1'b0);
    @(negedge clk);
    check("rst_rd.c_gnt", 64'(c_gnt), 64'(1'b1));
    next_cycle();
    set_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_rd.c_rvalid.%0d", i), 64'(c_rvalid), 64'(1'b0));
      if (i == 0)
        check("rst_rd.all_zero",
              64'({c_gnt, h_gnt, c_rvalid, h_rvalid, c_err, h_err, lock_active, mem_we,
                   mem_addr, mem_data, c_rdata, h_rdata}), 64'(0));
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lmc_mem_arbiter.md
# lmc_mem_arbiter

Two-port arbiter and sequencer for the shared 100-mailbox LMC memory. It sits between the memory and two requesters: the CPU core (fetch/load/store) and a host loader/debug port that preloads programs and inspects state. It serialises accesses, owns the memory's address, write-data and write-enable lines, returns read data with a fixed latency, and flags out-of-range mailboxes.

## Interface
- ADDR_W, 7, mailbox address width
- DATA_W, 11, word width
- MEM_DEPTH, 100, valid mailboxes 0..MEM_DEPTH-1
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- c_req / h_req  in  1  CPU / host access request
- c_we / h_we  in  1  1 = write, 0 = read
- c_addr / h_addr  in  ADDR_W  mailbox address
- c_wdata / h_wdata  in  DATA_W  write data
- h_lock  in  1  host requests exclusive ownership across transfers
- c_gnt / h_gnt  out  1  combinational grant; transfer occurs on an edge with req && gnt
- c_rvalid / h_rvalid  out  1  one-cycle read-data-valid pulse
- c_rdata / h_rdata  out  DATA_W  read data, held until the next read completion on that port
- c_err / h_err  out  1  one-cycle pulse: accepted address ≥ MEM_DEPTH
- lock_active  out  1  host lock is held
- mem_addr  out  ADDR_W  registered memory address
- mem_data  out  DATA_W  registered memory write data
- mem_we  out  1  registered write enable, one cycle wide
- mem_out  in  DATA_W  memory read data, combinational from mem_addr

## Operation
- Controller states are IDLE and RD_WAIT. The controller also keeps a lock_held flag and a round-robin pointer.
- IDLE: grants at most one port per cycle. Both gnt outputs are 0 in RD_WAIT.
- Grant selection, in priority order:
  - If lock_held, only the host is eligible.
  - Otherwise, if exactly one port requests, that port is granted.
  - Otherwise, if both request, the Configuration rule decides.
- Accepted write, in range: mem_addr/mem_data take the request values and mem_we=1 for one cycle. The state stays IDLE, so back-to-back writes run at one per cycle.
- Accepted read, in range: mem_addr takes the request address, the state goes to RD_WAIT, and the requester identity is recorded.
- RD_WAIT: sample mem_out into the recorded port's rdata, pulse its rvalid, and return to IDLE.
- Out of range (addr ≥ MEM_DEPTH): the request is accepted, mem_we stays 0, and memory is not touched.
  - Writes: err pulses in the next cycle.
  - Reads: err and rvalid both pulse in the next cycle, rdata=0, and no RD_WAIT.
- Lock:
  - A host transfer accepted with h_lock=1 sets lock_held. lock_active mirrors lock_held.
  - lock_held clears on any IDLE edge where h_lock=0, or when a host transfer is accepted with h_lock=0.
  - While locked, c_gnt=0 even if the host is idle.
- Requesters hold req/we/addr/wdata stable until they see gnt. Deasserting req before gnt is legal and withdraws the request.
- Reset values:
  - All gnt, rvalid, err, mem_we = 0.
  - rdata, mem_addr, mem_data = 0.
  - lock_active = 0, state IDLE, round-robin pointer favours the CPU.
- Reset asserted while in RD_WAIT: the pending read is discarded and no rvalid is produced after release.

## Timing
- gnt is combinational from req, state and lock_held in the same cycle; there are no zero-cycle loops through mem_out.
- Read latency: transfer at edge E0 (mem_addr updated) → rdata captured at E1 → rvalid high during the cycle after E1.
- Write: mem_we is high for the cycle after E0, and memory commits at E1.
- Read throughput is one read per 2 cycles; write throughput is one write per cycle.
- Write followed by read of the same address: the read, granted the cycle after the write, returns the new data, because the memory commits at the read's E0.

## Configuration
- LMC_ARB_RR_EN defined: round-robin.
  - On a simultaneous request, the port not granted last time wins.
  - The pointer updates on every accepted transfer.
- LMC_ARB_RR_EN undefined: fixed priority. The CPU always wins simultaneous requests, and the pointer logic is absent.
- h_lock overrides both modes.

## Test plan
- Host writes 901 to addr 5, then reads addr 5 → mem_we one cycle with mem_addr=5, mem_data=901; h_rvalid two cycles after read grant with h_rdata=901.
- Both ports read continuously, c_addr=1, h_addr=2 → with RR_EN, grants alternate C,H,C,H starting with C; without it, only C is granted.
- Host read with h_lock=1, then CPU requests for 10 cycles while h_lock=1 → c_gnt=0 throughout, lock_active=1; after h_lock=0, c_gnt rises on the next IDLE cycle.
- CPU writes to addr 100 and reads addr 127 → mem_we stays 0; c_err pulses on each; read gives c_rvalid=1, c_rdata=0 one cycle after grant.
- reset_n asserted the cycle after a CPU read grant → no c_rvalid after release; all outputs are 0.
- CPU write 42 to addr 9, then CPU read addr 9 granted the next cycle → c_rdata=42.
